writeback_arbiter: RTL
======================

Name: writeback_arbiter

Overview:
- Drives the register file write port (regWrite / writeReg / writeData) from two result sources:
  - the single-cycle ALU path, which has priority;
  - the variable-latency load path, which is buffered in a small FIFO.
- Resolves port conflicts and write-after-write ordering between the two sources.
- Exposes a pending-write mask so the hazard logic can stall readers of registers with queued load results.

Parameters:
- DEPTH, 4, load-result FIFO entries; power of 2, ≥2.
- DATA_W, 32, register data width.
- ADDR_W, 5, register address width (32 architectural registers).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- aluValid  input  1  ALU result present this cycle.
- aluReg  input  ADDR_W  ALU destination register.
- aluData  input  DATA_W  ALU result.
- memValid  input  1  load result offered this cycle.
- memReg  input  ADDR_W  load destination register.
- memData  input  DATA_W  load result.
- memReady  output  1  load result accepted this cycle (FIFO not full).
- regWrite  output  1  register file write enable, registered.
- writeReg  output  ADDR_W  register file write address, registered.
- writeData  output  DATA_W  register file write data, registered.
- pendingMask  output  2**ADDR_W  bit i set while a valid FIFO entry targets register i.
- fifoCount  output  $clog2(DEPTH)+1  occupied FIFO entries, including squashed ones.

Behaviour:
- Reset (reset=0, asynchronous):
  - regWrite, writeReg, writeData, fifoCount, pendingMask = 0; memReady = 1.
  - All entries invalid; head and tail pointers = 0.
- Latency: a selected write appears on the write port exactly 1 cycle after its source cycle.
- Load handshake:
  - A load is accepted when memValid && memReady; memReady = (fifoCount < DEPTH), from registered count only.
  - No push-while-pop when full: memReady stays 0 in that cycle.
- x0 handling:
  - aluValid with aluReg==0 is ignored and does not claim the port.
  - Accepted loads with memReg==0 are consumed and discarded (never queued, never written).
- Per-cycle selection, in priority order:
  - (1) ALU: aluValid && aluReg!=0 → write ALU result.
  - (2) FIFO head: FIFO non-empty → pop head; write it if the head is valid, otherwise regWrite=0 (the squashed slot burns one cycle).
  - (3) Load bypass: FIFO empty and accepted load with memReg!=0 → write it directly, no push.
  - (4) Otherwise regWrite=0.
- Any accepted load not written via (3) is pushed at the tail with valid=1.
- WAW squash: when (1) fires for register R:
  - every valid FIFO entry with reg==R is cleared to valid=0 that cycle;
  - a load accepted the same cycle with memReg==R is pushed already invalid. Loads are treated as older than a same-cycle ALU result.
- Squashed entries still occupy a slot until popped; fifoCount counts them.
- pendingMask is combinational from registered entry state: OR of one-hot(reg) over valid entries.
- Pointers wrap modulo DEPTH. Occupancy is tracked by fifoCount, not pointer compare.
- Simultaneous push and pop (not full): count unchanged, both pointers advance.
- Reset mid-operation discards all queued writes. A queued load result is lost; upstream must reissue.

Optional Feature:
- Macro WB_STATS_EN.
- Defined: adds two ports:
  - squashCount  output  16  saturating count of FIFO entries invalidated by the WAW squash;
  - conflictCount  output  16  saturating count of cycles where the FIFO was non-empty but the ALU took the port.
  - Both counters reset to 0 and hold at 16'hFFFF.
- Undefined: ports and counters absent; all other behaviour identical.

Decomposition:
- Package wb_pkg holds:
  - DATA_W and ADDR_W defaults;
  - typedef wb_entry_t {valid, reg[ADDR_W-1:0], data[DATA_W-1:0]};
  - the one-hot decode function used for pendingMask.
- Sub-module wb_fifo:
  - circular buffer of wb_entry_t with push, pop, count, and parallel squash-by-address compare;
  - outputs head entry and per-entry valid/reg for the mask.
- Top level holds the selection priority, output registers and the optional stats counters.

Test Plan:
- Reset, then memValid with memReg=5, memData=32'h0000_00AA, FIFO empty, no ALU → next cycle regWrite=1, writeReg=5, writeData=AA; fifoCount stays 0.
- Same cycle aluValid (aluReg=3, data=32'h11) and memValid (memReg=7, data=32'h22) → cycle+1 writes x3=11 with pendingMask[7]=1; cycle+2 writes x7=22 and pendingMask returns to 0.
- Queue loads to x9 and x10; then ALU writes x9=32'hBEEF → x9 entry squashed; the pop of that slot gives regWrite=0; x10 is written next; x9 remains BEEF. With WB_STATS_EN, squashCount=1.
- ALU busy every cycle for DEPTH+1 load offers → memReady drops to 0 after DEPTH accepts and fifoCount=DEPTH; after ALU idles, entries drain one per cycle in order.
- Load to x0 and ALU to x0 in the same cycle → no write, nothing queued, pendingMask=0.
- Assert reset low with 3 entries queued, asynchronously mid-cycle → outputs zero immediately, fifoCount=0, memReady=1; no stale write after reset releases.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared constants, FIFO entry type and register one-hot decode for the writeback arbiter.
package wb_pkg;

    localparam int unsigned WB_DATA_W = 32;
    localparam int unsigned WB_ADDR_W = 5;

    typedef struct packed {
        logic                 valid;
        logic [WB_ADDR_W-1:0] regAddr;
        logic [WB_DATA_W-1:0] data;
    } wb_entry_t;

    function automatic logic [2**WB_ADDR_W-1:0] wb_onehot(input logic [WB_ADDR_W-1:0] a);
        logic [2**WB_ADDR_W-1:0] v;
        v    = '0;
        v[a] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// Circular buffer of pending load results with parallel squash-by-register-address.
module wb_fifo
    import wb_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                i_push,
    input  wb_entry_t                           i_push_entry,
    input  logic                                i_pop,
    input  logic                                i_squash_en,
    input  logic [WB_ADDR_W-1:0]                i_squash_reg,
    output wb_entry_t                           o_head,
    output logic [$clog2(DEPTH):0]              o_count,
    output logic [DEPTH-1:0]                    o_valid,
    output logic [DEPTH-1:0][WB_ADDR_W-1:0]     o_reg
);

    localparam int unsigned PW = $clog2(DEPTH);

    wb_entry_t        r_mem [DEPTH];
    logic [PW-1:0]    r_head;
    logic [PW-1:0]    r_tail;
    logic [PW:0]      r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (i_squash_en && r_mem[i].valid && (r_mem[i].regAddr == i_squash_reg))
                    r_mem[i].valid <= 1'b0;
            end
            // Popped slots are invalidated so the pending mask only sees live entries.
            if (i_pop) begin
                r_mem[r_head].valid <= 1'b0;
                r_head              <= r_head + PW'(1);
            end
            if (i_push) begin
                r_mem[r_tail] <= i_push_entry;
                r_tail        <= r_tail + PW'(1);
            end
            unique case ({i_push, i_pop})
                2'b10:   r_count <= r_count + (PW+1)'(1);
                2'b01:   r_count <= r_count - (PW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_comb begin
        o_valid = '0;
        o_reg   = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            o_valid[i] = r_mem[i].valid;
            o_reg[i]   = r_mem[i].regAddr;
        end
    end

    assign o_head  = r_mem[r_head];
    assign o_count = r_count;

endmodule

// File: rtl/writeback_arbiter.sv
// Register-file write port arbiter: ALU priority, buffered loads, WAW squash, pending mask.
// Optional saturating squash/conflict counters when WB_STATS_EN is defined.
module writeback_arbiter
    import wb_pkg::*;
#(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned DATA_W = WB_DATA_W,
    parameter int unsigned ADDR_W = WB_ADDR_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     aluValid,
    input  logic [ADDR_W-1:0]        aluReg,
    input  logic [DATA_W-1:0]        aluData,
    input  logic                     memValid,
    input  logic [ADDR_W-1:0]        memReg,
    input  logic [DATA_W-1:0]        memData,
    output logic                     memReady,
    output logic                     regWrite,
    output logic [ADDR_W-1:0]        writeReg,
    output logic [DATA_W-1:0]        writeData,
    output logic [2**ADDR_W-1:0]     pendingMask,
    output logic [$clog2(DEPTH):0]   fifoCount
`ifdef WB_STATS_EN
    ,
    output logic [15:0]              squashCount,
    output logic [15:0]              conflictCount
`endif
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    wb_entry_t                      w_head;
    wb_entry_t                      w_push_entry;
    logic [CW-1:0]                  w_count;
    logic [DEPTH-1:0]               w_valid;
    logic [DEPTH-1:0][ADDR_W-1:0]   w_reg;
    logic                           w_alu_fire;
    logic                           w_accept;
    logic                           w_empty;
    logic                           w_pop;
    logic                           w_bypass;
    logic                           w_push;

    logic                           r_regWrite;
    logic [ADDR_W-1:0]              r_writeReg;
    logic [DATA_W-1:0]              r_writeData;

    assign memReady   = (w_count < FULL_CNT);
    assign w_empty    = (w_count == '0);
    assign w_alu_fire = aluValid && (aluReg != '0);
    assign w_accept   = memValid && memReady;
    assign w_pop      = !w_alu_fire && !w_empty;
    assign w_bypass   = !w_alu_fire && w_empty && w_accept && (memReg != '0);
    assign w_push     = w_accept && (memReg != '0) && !w_bypass;

    // A same-cycle load is older than the ALU result, so it enters the queue already dead.
    assign w_push_entry = '{valid:   !(w_alu_fire && (memReg == aluReg)),
                            regAddr: memReg,
                            data:    memData};

    wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk          (clk),
        .rst_n        (reset),
        .i_push       (w_push),
        .i_push_entry (w_push_entry),
        .i_pop        (w_pop),
        .i_squash_en  (w_alu_fire),
        .i_squash_reg (aluReg),
        .o_head       (w_head),
        .o_count      (w_count),
        .o_valid      (w_valid),
        .o_reg        (w_reg)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_regWrite  <= 1'b0;
            r_writeReg  <= '0;
            r_writeData <= '0;
        end else if (w_alu_fire) begin
            r_regWrite  <= 1'b1;
            r_writeReg  <= aluReg;
            r_writeData <= aluData;
        end else if (w_pop) begin
            r_regWrite <= w_head.valid;
            if (w_head.valid) begin
                r_writeReg  <= w_head.regAddr;
                r_writeData <= w_head.data;
            end
        end else if (w_bypass) begin
            r_regWrite  <= 1'b1;
            r_writeReg  <= memReg;
            r_writeData <= memData;
        end else begin
            r_regWrite <= 1'b0;
        end
    end

    always_comb begin
        pendingMask = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (w_valid[i]) pendingMask = pendingMask | wb_onehot(w_reg[i]);
        end
    end

    assign regWrite  = r_regWrite;
    assign writeReg  = r_writeReg;
    assign writeData = r_writeData;
    assign fifoCount = w_count;

`ifdef WB_STATS_EN
    logic [15:0]   r_squash_cnt;
    logic [15:0]   r_conflict_cnt;
    logic [CW-1:0] w_hits;
    logic [16:0]   w_sq_sum;

    always_comb begin
        w_hits = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (w_alu_fire && w_valid[i] && (w_reg[i] == aluReg)) w_hits = w_hits + CW'(1);
        end
    end

    assign w_sq_sum = {1'b0, r_squash_cnt} + 17'(w_hits);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_squash_cnt   <= '0;
            r_conflict_cnt <= '0;
        end else begin
            r_squash_cnt <= w_sq_sum[16] ? 16'hFFFF : w_sq_sum[15:0];
            if (w_alu_fire && !w_empty && (r_conflict_cnt != 16'hFFFF))
                r_conflict_cnt <= r_conflict_cnt + 16'd1;
        end
    end

    assign squashCount   = r_squash_cnt;
    assign conflictCount = r_conflict_cnt;
`endif

endmodule
